// File: rtl/serial_logic_seq.sv
// Bit-serial 32-bit logic unit: applies AND/OR/XOR/NOR one nibble per clock
// through a single shared 4-bit slice, with a three-state IDLE/RUN/DONE sequencer.
module serial_logic_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] R,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  r_state;
   logic [2:0]  r_count;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_op;
   logic [31:0] r_result;

   logic [4:0]  w_bitBase;
   logic [3:0]  w_aNib;
   logic [3:0]  w_bNib;
   logic [3:0]  w_slice;
   logic        w_accept;

   assign w_bitBase = {r_count, 2'b00};
   assign w_aNib    = r_a[w_bitBase +: 4];
   assign w_bNib    = r_b[w_bitBase +: 4];
   assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));

   // The one shared slice; only the latched op steers it, never the live input.
   always_comb begin
      w_slice = 4'h0;
      case (r_op)
         2'b00:   w_slice = w_aNib & w_bNib;
         2'b01:   w_slice = w_aNib | w_bNib;
         2'b10:   w_slice = w_aNib ^ w_bNib;
         default: w_slice = ~(w_aNib | w_bNib);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_count  <= 3'd0;
         r_a      <= 32'h0;
         r_b      <= 32'h0;
         r_op     <= 2'b00;
         r_result <= 32'h0;
      end else if (w_accept) begin
         r_state  <= RUN;
         r_count  <= 3'd0;
         r_a      <= A;
         r_b      <= B;
         r_op     <= op;
         r_result <= 32'h0;
      end else begin
         case (r_state)
            RUN: begin
               r_result[w_bitBase +: 4] <= w_slice;
               r_count                  <= r_count + 3'd1;
               // The last nibble write coincides with the counter wrapping to 0.
               if (r_count == 3'd7) begin
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            IDLE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign R    = r_result;
   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_logic_seq.sv
// Directed and randomized checks of serial_logic_seq against a whole-word
// reference model (result = A op B, visible nibble by nibble as edges pass).
module tb_serial_logic_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] R;
   logic        busy;
   logic        done;

   int total;
   int bad;

   serial_logic_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .R     (R),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the whole result word computed at once.
   function automatic logic [31:0] modelOf(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      case (o)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // After k writing edges only the low k nibbles of the result are visible.
   function automatic logic [31:0] partialOf(input logic [31:0] full, input int k);
      logic [63:0] mask;
      mask = (64'd1 << (4 * k)) - 64'd1;
      return full & mask[31:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b);
      start = s;
      op    = o;
      A     = a;
      B     = b;
   endtask

   // One full operation: accept, scramble inputs, check every cycle through t9.
   task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic [31:0] expected);
      @(negedge clk);
      applyStimulus(1'b1, o, a, b);
      @(negedge clk);
      applyStimulus(1'b0, 2'($urandom), $urandom, $urandom);
      checkOutput({tag, " t0 busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " t0 done"}, 32'(done), 32'd0);
      checkOutput({tag, " t0 R"}, R, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k < 8) begin
            checkOutput($sformatf("%s t%0d busy", tag, k), 32'(busy), 32'd1);
            checkOutput($sformatf("%s t%0d done", tag, k), 32'(done), 32'd0);
            checkOutput($sformatf("%s t%0d R", tag, k), R, partialOf(expected, k));
         end else begin
            checkOutput({tag, " t8 busy"}, 32'(busy), 32'd0);
            checkOutput({tag, " t8 done"}, 32'(done), 32'd1);
            checkOutput({tag, " t8 R"}, R, expected);
         end
      end
      @(negedge clk);
      checkOutput({tag, " t9 done"}, 32'(done), 32'd0);
      checkOutput({tag, " t9 busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " t9 R hold"}, R, expected);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  ro;
      total = 0;
      bad   = 0;

      // Reset with start also high: start must be ignored.
      reset = 1'b1;
      applyStimulus(1'b1, 2'b10, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (2) @(negedge clk);
      checkOutput("reset R", R, 32'h0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      reset = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("post-reset busy", 32'(busy), 32'd0);
      checkOutput("post-reset R", R, 32'h0);

      // Directed operations.
      runOp("or27", 32'hF0F0_1234, 32'h0F0F_0001, 2'b01, 32'hFFFF_1235);
      runOp("and28", 32'hDEAD_BEEF, 32'h0000_FFFF, 2'b00, 32'h0000_BEEF);
      runOp("or28", 32'hDEAD_BEEF, 32'h0000_FFFF, 2'b01, 32'hDEAD_FFFF);
      runOp("xor28", 32'hDEAD_BEEF, 32'h0000_FFFF, 2'b10, 32'hDEAD_4110);
      runOp("nor28", 32'hDEAD_BEEF, 32'h0000_FFFF, 2'b11, 32'h2152_0000);
      runOp("prog29", 32'hFFFF_FFFF, 32'h0, 2'b01, 32'hFFFF_FFFF);

      // Start and operand changes during RUN must be ignored.
      @(negedge clk);
      applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 2'b11, 32'h0, 32'hFFFF_FFFF);
      @(negedge clk);
      applyStimulus(1'b0, 2'b11, 32'h0, 32'hFFFF_FFFF);
      checkOutput("iso t3 busy", 32'(busy), 32'd1);
      checkOutput("iso t3 R", R, 32'h0000_0FFF);
      repeat (5) @(negedge clk);
      checkOutput("iso t8 done", 32'(done), 32'd1);
      checkOutput("iso t8 R", R, 32'hFFFF_FFFF);
      @(negedge clk);
      checkOutput("iso t9 done", 32'(done), 32'd0);
      checkOutput("iso t9 busy", 32'(busy), 32'd0);

      // Back-to-back: start held high into DONE re-accepts the new request.
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 32'h0000_00F0, 32'h0000_000F);
      @(negedge clk);
      applyStimulus(1'b1, 2'b10, 32'h1, 32'h3);
      repeat (8) @(negedge clk);
      checkOutput("b2b t8 done", 32'(done), 32'd1);
      checkOutput("b2b t8 R", R, 32'h0000_00FF);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
      checkOutput("b2b t9 done", 32'(done), 32'd0);
      checkOutput("b2b t9 busy", 32'(busy), 32'd1);
      checkOutput("b2b t9 R", R, 32'h0);
      repeat (7) @(negedge clk);
      checkOutput("b2b t16 done", 32'(done), 32'd0);
      @(negedge clk);
      checkOutput("b2b t17 done", 32'(done), 32'd1);
      checkOutput("b2b t17 R", R, 32'h0000_0002);
      @(negedge clk);
      checkOutput("b2b t18 done", 32'(done), 32'd0);

      // Reset in the middle of an operation abandons it without a done pulse.
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 32'hAAAA_AAAA, 32'h5555_5555);
      @(negedge clk);
      applyStimulus(1'b0, 2'b01, 32'h0, 32'h0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midrst R", R, 32'h0);
      checkOutput("midrst busy", 32'(busy), 32'd0);
      checkOutput("midrst done", 32'(done), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("midrst quiet %0d", i), 32'(done), 32'd0);
      end
      runOp("after-rst", 32'h1357_9BDF, 32'h0F0F_F0F0, 2'b10, 32'h1C58_6B2F);

      // Randomized operations against the whole-word model.
      for (int n = 0; n < 20; n++) begin
         ra = $urandom;
         rb = $urandom;
         ro = 2'($urandom_range(0, 3));
         runOp($sformatf("rand%0d", n), ra, rb, ro, modelOf(ro, ra, rb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
